noc_pe_interface: RTL and testbench

NOC_PE_INTERFACE -- requirements
Module: noc_pe_interface

---
 rtl/noc_pkg.sv | 21 ++
 rtl/noc_sync_fifo.sv | 50 +++++
 rtl/noc_pe_interface.sv | 91 +++++++++
 tb/tb_noc_pe_interface.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared packet layout helpers for the NoC PE interface: field offsets,
// total packet width and the drop-counter width.
package noc_pkg;

  localparam int DEST_X_LSB = 0;
  localparam int DROP_CNT_W = 16;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = {DROP_CNT_W{1'b1}};

  function automatic int dest_y_lsb(input int x_size);
    return x_size;
  endfunction

  function automatic int payload_lsb(input int x_size, input int y_size);
    return x_size + y_size;
  endfunction

  function automatic int total_width(input int x_size, input int y_size, input int data_width);
    return x_size + y_size + data_width;
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// First-word-fall-through synchronous FIFO with an occupancy count; storage is
// not reset, only pointers and count.
module noc_sync_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [width-1:0]         wr_data,
  input  logic                     pop,
  output logic [width-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   count
);

  localparam int AW = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == ($clog2(depth)+1)'(depth));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal only when a pop frees a slot this cycle.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/noc_pe_interface.sv
// PE-side network interface: TX FIFO toward the switch, RX FIFO from it with
// overflow tracking. Define NOC_PE_IF_DROP_CNT_EN to enable the drop counter.
module noc_pe_interface
  import noc_pkg::*;
#(
  parameter int data_width = 32,
  parameter int x_size     = 1,
  parameter int y_size     = 1,
  parameter int fifo_depth = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 s_valid,
  input  logic [data_width-1:0]                s_data,
  input  logic [x_size-1:0]                    s_dest_x,
  input  logic [y_size-1:0]                    s_dest_y,
  output logic                                 s_ready,
  output logic                                 o_valid_noc,
  output logic [x_size+y_size+data_width-1:0]  o_data_noc,
  input  logic                                 i_ready_noc,
  input  logic                                 i_valid_noc,
  input  logic [x_size+y_size+data_width-1:0]  i_data_noc,
  output logic                                 m_valid,
  output logic [data_width-1:0]                m_data,
  input  logic                                 m_ready,
  output logic                                 rx_overflow,
  output logic [DROP_CNT_W-1:0]                rx_drop_count
);

  localparam int PKT_W  = total_width(x_size, y_size, data_width);
  localparam int PAY_LO = payload_lsb(x_size, y_size);
  localparam int CNT_W  = $clog2(fifo_depth) + 1;

  logic             tx_full, tx_empty, tx_push, tx_pop;
  logic             rx_full, rx_empty, rx_push, rx_pop, rx_drop;
  logic [PKT_W-1:0] tx_pkt, rx_head;
  logic [CNT_W-1:0] tx_count, rx_count;

  // TX: PE -> switch; no push accepted while full, even with a concurrent pop.
  assign tx_pkt      = {s_data, s_dest_y, s_dest_x};
  assign s_ready     = !tx_full;
  assign tx_push     = s_valid && !tx_full;
  assign o_valid_noc = !tx_empty;
  assign tx_pop      = o_valid_noc && i_ready_noc;

  noc_sync_fifo #(.width(PKT_W), .depth(fifo_depth)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (tx_push),
    .wr_data (tx_pkt),
    .pop     (tx_pop),
    .rd_data (o_data_noc),
    .full    (tx_full),
    .empty   (tx_empty),
    .count   (tx_count)
  );

  // RX: switch -> PE; the switch cannot be stalled, so a full FIFO drops.
  assign m_valid = !rx_empty;
  assign rx_pop  = m_valid && m_ready;
  assign rx_push = i_valid_noc && (!rx_full || rx_pop);
  assign rx_drop = i_valid_noc && rx_full && !rx_pop;
  assign m_data  = rx_head[PKT_W-1:PAY_LO];

  noc_sync_fifo #(.width(PKT_W), .depth(fifo_depth)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (rx_push),
    .wr_data (i_data_noc),
    .pop     (rx_pop),
    .rd_data (rx_head),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (rx_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rx_overflow <= 1'b0;
    else if (rx_drop) rx_overflow <= 1'b1;
  end

`ifdef NOC_PE_IF_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          rx_drop_count <= '0;
    else if (rx_drop && rx_drop_count != DROP_CNT_MAX) rx_drop_count <= rx_drop_count + 1'b1;
  end
`else
  assign rx_drop_count = '0;
`endif

endmodule

// File: tb/tb_noc_pe_interface.sv
// Directed self-checking bench for noc_pe_interface at default parameters.
module tb_noc_pe_interface;

  localparam int DW = 32;
  localparam int PW = 34;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic [0:0]    s_dest_x, s_dest_y;
  logic          s_ready;
  logic          o_valid_noc;
  logic [PW-1:0] o_data_noc;
  logic          i_ready_noc;
  logic          i_valid_noc;
  logic [PW-1:0] i_data_noc;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic          rx_overflow;
  logic [15:0]   rx_drop_count;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef NOC_PE_IF_DROP_CNT_EN
  localparam logic [15:0] EXP_DROPS = 16'd2;
`else
  localparam logic [15:0] EXP_DROPS = 16'd0;
`endif

  always #5 clk = ~clk;

  noc_pe_interface dut (
    .clk           (clk),
    .rst           (rst),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_dest_x      (s_dest_x),
    .s_dest_y      (s_dest_y),
    .s_ready       (s_ready),
    .o_valid_noc   (o_valid_noc),
    .o_data_noc    (o_data_noc),
    .i_ready_noc   (i_ready_noc),
    .i_valid_noc   (i_valid_noc),
    .i_data_noc    (i_data_noc),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_ready       (m_ready),
    .rx_overflow   (rx_overflow),
    .rx_drop_count (rx_drop_count)
  );

  function automatic logic [PW-1:0] pkt(input logic [DW-1:0] d, input logic dy, input logic dx);
    return {d, dy, dx};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [PW-1:0] held;

  initial begin
    rst = 1'b1; s_valid = 0; s_data = '0; s_dest_x = '0; s_dest_y = '0;
    i_ready_noc = 0; i_valid_noc = 0; i_data_noc = '0; m_ready = 0;
    cyc(); cyc();
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    chk("rst_o_valid", 64'(o_valid_noc), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_overflow", 64'(rx_overflow), 64'd0);
    chk("rst_drop_cnt", 64'(rx_drop_count), 64'd0);
    rst = 1'b0;
    cyc();

    // Single packet A5 to (1,0), switch ready
    s_valid = 1; s_data = 32'hA5; s_dest_x = 1; s_dest_y = 0; i_ready_noc = 1;
    cyc();
    s_valid = 0;
    chk("tx1_valid", 64'(o_valid_noc), 64'd1);
    chk("tx1_data", 64'(o_data_noc), 64'h295);
    cyc();
    chk("tx1_popped", 64'(o_valid_noc), 64'd0);

    // Backpressure: 5 pushes into depth 4
    i_ready_noc = 0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("tx_ready_%0d", i), 64'(s_ready), (i < 4) ? 64'd1 : 64'd0);
      s_valid = 1; s_data = 32'h10 + i; s_dest_x = i[0]; s_dest_y = i[1];
      cyc();
    end
    s_valid = 0;
    chk("tx_full_ready", 64'(s_ready), 64'd0);
    held = o_data_noc;
    chk("tx_head", 64'(o_data_noc), 64'(pkt(32'h10, 1'b0, 1'b0)));
    cyc(); cyc();
    chk("tx_head_stable", 64'(o_data_noc), 64'(held));
    i_ready_noc = 1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("tx_drain_v%0d", k), 64'(o_valid_noc), 64'd1);
      chk($sformatf("tx_drain_d%0d", k), 64'(o_data_noc),
          64'(pkt(32'h10 + k, k[1], k[0])));
      cyc();
    end
    chk("tx_fifth_dropped", 64'(o_valid_noc), 64'd0);
    i_ready_noc = 0;

    // RX overflow: 6 beats, PE stalled
    for (int i = 0; i < 6; i++) begin
      i_valid_noc = 1; i_data_noc = pkt(32'h100 + i, 1'b1, 1'b0);
      cyc();
    end
    i_valid_noc = 0;
    chk("rx_m_valid", 64'(m_valid), 64'd1);
    chk("rx_head", 64'(m_data), 64'h100);
    chk("rx_overflow", 64'(rx_overflow), 64'd1);
    chk("rx_drop_cnt", 64'(rx_drop_count), 64'(EXP_DROPS));

    // Full RX FIFO with concurrent pop and push: no drop
    i_valid_noc = 1; i_data_noc = pkt(32'h200, 1'b0, 1'b1); m_ready = 1;
    cyc();
    i_valid_noc = 0; m_ready = 0;
    chk("rx_bypass_nodrop", 64'(rx_drop_count), 64'(EXP_DROPS));
    chk("rx_bypass_head", 64'(m_data), 64'h101);
    m_ready = 1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rx_drain_%0d", k), 64'(m_data), (k < 3) ? 64'(32'h101 + k) : 64'h200);
      cyc();
    end
    chk("rx_drained", 64'(m_valid), 64'd0);
    m_ready = 0;
    chk("overflow_sticky", 64'(rx_overflow), 64'd1);

    // Half-full both ways, then asynchronous reset
    for (int i = 0; i < 2; i++) begin
      s_valid = 1; s_data = 32'h300 + i; i_valid_noc = 1; i_data_noc = pkt(32'h400 + i, 1'b0, 1'b0);
      cyc();
    end
    s_valid = 0; i_valid_noc = 0;
    chk("half_tx_valid", 64'(o_valid_noc), 64'd1);
    chk("half_rx_valid", 64'(m_valid), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_o_valid", 64'(o_valid_noc), 64'd0);
    chk("arst_m_valid", 64'(m_valid), 64'd0);
    chk("arst_s_ready", 64'(s_ready), 64'd1);
    chk("arst_overflow", 64'(rx_overflow), 64'd0);
    chk("arst_drop_cnt", 64'(rx_drop_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc();
    chk("post_rst_empty", 64'(o_valid_noc), 64'd0);
    s_valid = 1; s_data = 32'h55; s_dest_x = 0; s_dest_y = 1;
    cyc();
    s_valid = 0;
    chk("post_rst_push", 64'(o_data_noc), 64'(pkt(32'h55, 1'b1, 1'b0)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
